// File: rtl/de0_nano_soc_qsys_pio_bidir_n.sv
// Avalon-MM bidirectional PIO: per-bit direction, input synchroniser, OUTSET/OUTCLR helpers.
// Define PIO_EDGE_CAPTURE_EN to build the edge-capture block (IRQMASK, EDGECAP and irq).
module de0_nano_soc_qsys_pio_bidir_n #(
    parameter int unsigned       WIDTH       = 8,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter int unsigned       EDGE_TYPE   = 0,
    parameter logic [WIDTH-1:0]  RESET_OUT   = '0,
    parameter logic [WIDTH-1:0]  RESET_DIR   = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    inout  wire  [WIDTH-1:0]  bidir_port
);

    // Bus timing: no wait states. A write lands on the clk edge where chipselect & ~write_n;
    // readdata always shows the register addressed in the previous cycle (no read strobe).
    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    logic                              wr;
    logic [WIDTH-1:0]                  wd;
    logic [WIDTH-1:0]                  data_out;
    logic [WIDTH-1:0]                  data_dir;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  data_sync;
    logic [WIDTH-1:0]                  irq_mask;
    logic [WIDTH-1:0]                  edge_cap;
    logic [31:0]                       rd_mux;
    logic                              unused_writedata;

    assign wr        = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign data_sync = sync_q[SYNC_STAGES-1];
    // Upper writedata bits are deliberately dropped.
    assign unused_writedata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= RESET_OUT;
            data_dir <= RESET_DIR;
        end else if (wr) begin
            case (address)
                ADDR_DATA:   data_out <= wd;
                ADDR_DIR:    data_dir <= wd;
                ADDR_OUTSET: data_out <= data_out | wd;
                ADDR_OUTCLR: data_out <= data_out & ~wd;
                default:     ;
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        assign bidir_port[i] = data_dir[i] ? data_out[i] : 1'bz;
    end

    // Pins are sampled whether driven or not, so DATA reads back the real pin level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bidir_port};
        end
    end

`ifdef PIO_EDGE_CAPTURE_EN
    localparam int unsigned ARM_MAX = SYNC_STAGES + 1;
    localparam int unsigned ARM_W   = $clog2(ARM_MAX + 1);

    logic [WIDTH-1:0] data_prev;
    logic [WIDTH-1:0] edge_evt;
    logic [WIDTH-1:0] cap_clr;
    logic [ARM_W-1:0] arm_cnt;
    logic             armed;

    // Stay disarmed until the synchroniser holds real pin samples, so pins high at reset do not look like rises.
    assign armed   = (arm_cnt == ARM_W'(ARM_MAX));
    assign cap_clr = (wr && address == ADDR_EDGECAP) ? wd : '0;

    always_comb begin
        edge_evt = '0;
        if (EDGE_TYPE == 0) begin
            edge_evt = data_sync & ~data_prev;
        end else if (EDGE_TYPE == 1) begin
            edge_evt = ~data_sync & data_prev;
        end else begin
            edge_evt = data_sync ^ data_prev;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_prev <= '0;
            irq_mask  <= '0;
            edge_cap  <= '0;
            arm_cnt   <= '0;
            irq       <= 1'b0;
        end else begin
            data_prev <= data_sync;
            if (wr && address == ADDR_IRQMASK) begin
                irq_mask <= wd;
            end
            // Set after clear: an edge arriving with a W1C of the same bit is kept.
            edge_cap <= (edge_cap & ~cap_clr) | (armed ? edge_evt : '0);
            if (!armed) begin
                arm_cnt <= arm_cnt + ARM_W'(1);
            end
            irq <= |(edge_cap & irq_mask);
        end
    end
`else
    assign irq_mask = '0;
    assign edge_cap = '0;
    assign irq      = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:    rd_mux[WIDTH-1:0] = data_sync;
            ADDR_DIR:     rd_mux[WIDTH-1:0] = data_dir;
            ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irq_mask;
            ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edge_cap;
            default:      ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_de0_nano_soc_qsys_pio_bidir_n.sv
// Bench for de0_nano_soc_qsys_pio_bidir_n (WIDTH=8, SYNC_STAGES=2, RESET_DIR=0x0F, RESET_OUT=0x05).
// Edge-capture scenarios run when PIO_EDGE_CAPTURE_EN is defined; otherwise the disabled map is checked.
module tb_de0_nano_soc_qsys_pio_bidir_n;

    localparam int         W       = 8;
    localparam int         S       = 2;
    localparam logic [7:0] RST_OUT = 8'h05;
    localparam logic [7:0] RST_DIR = 8'h0F;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b0;
    logic [2:0]  address    = 3'd1;
    logic        chipselect = 1'b0;
    logic        write_n    = 1'b1;
    logic [31:0] writedata  = '0;
    wire  [31:0] readdata;
    wire         irq;
    wire  [W-1:0] bidir_port;

    logic [W-1:0] tb_drive = 8'hA0;
    logic [W-1:0] tb_en    = 8'hF0;

    for (genvar g = 0; g < W; g++) begin : g_tb_pin
        assign bidir_port[g] = tb_en[g] ? tb_drive[g] : 1'bz;
    end

    de0_nano_soc_qsys_pio_bidir_n #(
        .WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(0), .RESET_OUT(RST_OUT), .RESET_DIR(RST_DIR)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
        .bidir_port(bidir_port)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pins go through a delay line of S samples; registers follow the bus writes.
    logic [W-1:0] m_out  = RST_OUT;
    logic [W-1:0] m_dir  = RST_DIR;
    logic [W-1:0] m_mask = '0;
    logic [W-1:0] m_cap  = '0;
    logic [31:0]  m_rd   = '0;
    logic         m_irq  = 1'b0;
    int           m_edges = 0;
    logic [W-1:0] hist[$];

    always @(posedge clk or negedge reset_n) begin
        logic [W-1:0] pin_lvl, sync, prev, wd, rise;
        logic         wr;
        if (!reset_n) begin
            m_out = RST_OUT; m_dir = RST_DIR; m_mask = '0; m_cap = '0;
            m_rd = '0; m_irq = 1'b0; m_edges = 0;
            hist.delete();
            for (int i = 0; i <= S; i++) hist.push_back('0);
        end else begin
            pin_lvl = (m_out & m_dir) | (tb_drive & tb_en & ~m_dir);
            sync    = hist[S-1];
            prev    = hist[S];
            wr      = chipselect && !write_n;
            wd      = writedata[W-1:0];
            case (address)
                3'd0:    m_rd = 32'(sync);
                3'd1:    m_rd = 32'(m_dir);
`ifdef PIO_EDGE_CAPTURE_EN
                3'd2:    m_rd = 32'(m_mask);
                3'd3:    m_rd = 32'(m_cap);
`endif
                default: m_rd = '0;
            endcase
`ifdef PIO_EDGE_CAPTURE_EN
            m_irq = |(m_cap & m_mask);
            rise  = (m_edges >= S + 1) ? (sync & ~prev) : '0;
            m_cap = (wr && address == 3'd3) ? ((m_cap & ~wd) | rise) : (m_cap | rise);
            if (wr && address == 3'd2) m_mask = wd;
`else
            rise  = '0;
            m_irq = 1'b0;
`endif
            if (wr) begin
                case (address)
                    3'd0:    m_out = wd;
                    3'd1:    m_dir = wd;
                    3'd4:    m_out = m_out | wd;
                    3'd5:    m_out = m_out & ~wd;
                    default: ;
                endcase
            end
            hist.push_front(pin_lvl);
            void'(hist.pop_back());
            m_edges++;
        end
    end

    // Compare process: every falling edge, outputs against the model.
    always @(negedge clk) begin
        check_val("readdata", readdata, m_rd);
        check_val("irq", 32'(irq), 32'(m_irq));
        check_val("driven_pins", 32'(bidir_port & m_dir), 32'(m_out & m_dir));
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    task automatic read_expect(input logic [2:0] a, input logic [31:0] exp, input string name);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        @(posedge clk); #1;
        chipselect = 1'b0;
        check_val(name, readdata, exp);
    endtask

    initial begin
        int n;
        // Reset: readdata held 0 even with DIR addressed, low nibble driven with RESET_OUT.
        idle(3);
        check_val("rst_readdata", readdata, 32'h0);
        check_val("rst_pins_lo", 32'(bidir_port & 8'h0F), 32'h05);
        reset_n = 1'b1;
        read_expect(3'd1, 32'h0F, "dir_reset");
        idle(S + 1);
        // Upper nibble undriven by the PIO, so the bench's 0xA shows through.
        read_expect(3'd0, 32'hA5, "data_reset_mix");

        write_reg(3'd0, 32'hA5);
        write_reg(3'd1, 32'hFF);
        tb_en = '0;
        #1;
        check_val("pins_a5", 32'(bidir_port), 32'hA5);
        idle(S + 1);
        read_expect(3'd0, 32'hA5, "loopback_a5");
        write_reg(3'd4, 32'h0A);
        idle(S + 1);
        read_expect(3'd0, 32'hAF, "outset_af");
        write_reg(3'd5, 32'h81);
        idle(S + 1);
        read_expect(3'd0, 32'h2E, "outclr_2e");

        write_reg(3'd0, 32'hFFFF_FF3C);
        #1;
        check_val("pins_3c", 32'(bidir_port), 32'h3C);
        write_reg(3'd1, 32'hABCD_00FF);
        read_expect(3'd1, 32'hFF, "dir_upper_ignored");
        write_reg(3'd6, 32'hFF);
        write_reg(3'd7, 32'h00);
        #1;
        check_val("pins_after_67", 32'(bidir_port), 32'h3C);
        read_expect(3'd4, 32'h0, "outset_reads_0");
        read_expect(3'd5, 32'h0, "outclr_reads_0");
        read_expect(3'd6, 32'h0, "addr6_reads_0");
        read_expect(3'd7, 32'h0, "addr7_reads_0");

        // Hand pins over to the bench.
        write_reg(3'd0, 32'h00);
        write_reg(3'd1, 32'h00);
        tb_en = '1; tb_drive = '0;
        idle(S + 2);
`ifdef PIO_EDGE_CAPTURE_EN
        write_reg(3'd2, 32'h01);
        read_expect(3'd2, 32'h01, "irqmask_rw");
        idle(2);
        tb_drive = 8'h01;
        n = 0;
        while (!irq && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("irq_latency", 32'(n), 32'(S + 2));
        read_expect(3'd3, 32'h01, "edgecap_rise");
        write_reg(3'd3, 32'h01);
        idle(1);
        check_val("irq_after_w1c", 32'(irq), 32'h0);

        tb_drive = 8'h00;
        idle(4);
        tb_drive = 8'h01;
        idle(2);
        write_reg(3'd3, 32'h01);
        idle(1);
        check_val("irq_same_cycle", 32'(irq), 32'h1);
        read_expect(3'd3, 32'h01, "edgecap_same_cycle");

        write_reg(3'd3, 32'h01);
        tb_drive = 8'h00;
        idle(S + 3);
        read_expect(3'd3, 32'h00, "fall_ignored");
        tb_drive = 8'h02;
        idle(S + 3);
        check_val("irq_masked", 32'(irq), 32'h0);
        read_expect(3'd3, 32'h02, "edgecap_masked_bit");
        write_reg(3'd3, 32'hFF);
`else
        write_reg(3'd2, 32'hFF);
        tb_drive = 8'hFF;
        idle(S + 3);
        tb_drive = 8'h00;
        idle(S + 3);
        tb_drive = 8'h55;
        idle(S + 3);
        check_val("irq_disabled", 32'(irq), 32'h0);
        read_expect(3'd0, 32'h55, "input_55");
        read_expect(3'd2, 32'h0, "addr2_reads_0");
        read_expect(3'd3, 32'h0, "addr3_reads_0");
`endif

        // Mid-run reset with pins high across release: no false edge.
        reset_n = 1'b0;
        tb_en = 8'hF0; tb_drive = 8'hF0;
        #1;
        check_val("midrst_pins_lo", 32'(bidir_port & 8'h0F), 32'h05);
        idle(3);
        reset_n = 1'b1;
        write_reg(3'd2, 32'hFF);
        idle(S + 4);
        check_val("arm_irq", 32'(irq), 32'h0);
        read_expect(3'd3, 32'h0, "arm_edgecap");
        read_expect(3'd0, 32'hF5, "data_after_midrst");
        read_expect(3'd1, 32'h0F, "dir_after_midrst");

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (errors=%0d checks=%0d)", errors, checks);
        $fatal(1);
    end

endmodule
